// File: rtl/frame_averager.sv
// Purpose : averages N_FRAMES consecutive frames of M signed 32-bit samples per index.
// Latency : first averaged word is offered the cycle after the final sample is registered.
// Backpressure: out_valid/out_ready handshake; the output word holds while out_ready is low.
//
// Ports:
//   clk, reset_n          - single rising-edge clock, asynchronous active-low reset
//   start                 - one-cycle run request, honoured only when idle
//   data_valid, data      - upstream sample stream (two's complement)
//   busy                  - run in progress (accumulating or dumping)
//   out_valid, out_ready  - output handshake
//   out_data, out_last    - averaged word and marker for index M-1
//   done                  - one-cycle pulse after the last word transfers
//   dropped               - sticky: a sample arrived while not accumulating
module frame_averager #(
  parameter int M        = 16,
  parameter int N_FRAMES = 8,
  parameter int ACC_W    = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        data_valid,
  input  logic [31:0] data,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        done,
  output logic        dropped
);

  localparam int LOG2N = $clog2(N_FRAMES);
  localparam int IDX_W = $clog2(M);
  // A one-frame run still needs a 1-bit frame counter to keep widths legal.
  localparam int FR_W  = (LOG2N > 0) ? LOG2N : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DUMP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd_idx;
  logic [FR_W-1:0]  frame;
  logic [ACC_W-1:0] acc [M];
  logic [ACC_W-1:0] sample_ext;

  logic accept;
  logic idx_last;
  logic frame_last;
  logic rd_last;
  logic xfer;

  assign sample_ext = ACC_W'($signed(data));
  assign accept     = (state == S_ACCUM) && data_valid;
  assign idx_last   = (idx == IDX_W'(M - 1));
  assign frame_last = (frame == FR_W'(N_FRAMES - 1));
  assign rd_last    = (rd_idx == IDX_W'(M - 1));
  assign xfer       = (state == S_DUMP) && out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (accept && idx_last && frame_last) state_nxt = S_DUMP;
      S_DUMP:  if (xfer && rd_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. out_data is forced to zero outside DUMP so reset shows a clean bus
  // even though the accumulator array itself is never reset.
  always_comb begin
    busy      = (state == S_ACCUM) || (state == S_DUMP);
    out_valid = (state == S_DUMP);
    out_last  = out_valid && rd_last;
    out_data  = out_valid ? acc[rd_idx][LOG2N +: 32] : 32'd0;
  end

  // Counters and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      rd_idx  <= '0;
      frame   <= '0;
      dropped <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= xfer && rd_last;

      if (state == S_IDLE && start) begin
        idx     <= '0;
        frame   <= '0;
        dropped <= 1'b0;
      end else if (data_valid && state != S_ACCUM) begin
        dropped <= 1'b1;
      end

      // M is a power of two, so the natural counter wrap gives M-1 -> 0.
      if (accept) begin
        idx <= idx + 1'b1;
        if (idx_last) frame <= frame + 1'b1;
      end

      if (accept && idx_last && frame_last) begin
        rd_idx <= '0;
      end else if (xfer) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Accumulator array: the first frame overwrites, so no clear pass and no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (frame == '0) begin
        acc[idx] <= sample_ext;
      end else begin
        acc[idx] <= acc[idx] + sample_ext;
      end
    end
  end

endmodule
